seq_detector_param: RTL and testbench

- Parametrised serial bit-pattern detector; the next generation of the single-pattern fixed FSM detector.
- Accepts one serial bit per qualified cycle and compares the most recent PATTERN_W bits against a runtime-programmable pattern.
- Raises a one-cycle match pulse, supports overlapping and non-overlapping modes, and keeps a saturating match count.
- Sits between a serial receive front-end and control logic that reacts to framing/sync words.

---
 rtl/seq_det_pkg.sv | 16 +
 rtl/seq_detector_param_sat_counter.sv | 22 ++
 rtl/seq_detector_param.sv | 77 +++++++
 tb/tb_seq_detector_param.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

    localparam int DEF_PATTERN_W   = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int MODE_NO_OVERLAP = 0;
    localparam int MODE_OVERLAP    = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with programmable pattern and saturating count.
// Optional don't-care mask input enabled by SEQDET_MASK_EN.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter  int PATTERN_W = DEF_PATTERN_W,
    parameter  int OVERLAP   = MODE_OVERLAP,
    parameter  int CNT_W     = DEF_CNT_W,
    localparam int FILL_W    = clog2(PATTERN_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic                 inp,
    input  logic [PATTERN_W-1:0] cfg_pattern,
`ifdef SEQDET_MASK_EN
    input  logic [PATTERN_W-1:0] cfg_mask,
`endif
    output logic                 match,
    output logic [CNT_W-1:0]     match_cnt,
    output logic [FILL_W-1:0]    fill
);

    localparam logic [FILL_W-1:0] FULL = FILL_W'(PATTERN_W);

    logic [PATTERN_W-1:0] hist;
    logic [PATTERN_W-1:0] hist_nx;
    logic [PATTERN_W-1:0] diff;
    logic [FILL_W-1:0]    fill_nx;
    logic                 hit;

    always_comb begin
        hist_nx = {hist[PATTERN_W-2:0], inp};
        fill_nx = (fill == FULL) ? fill : fill + FILL_W'(1);
`ifdef SEQDET_MASK_EN
        diff    = (hist_nx ^ cfg_pattern) & ~cfg_mask;
`else
        diff    = hist_nx ^ cfg_pattern;
`endif
        hit     = in_valid && (fill_nx == FULL) && (diff == '0);
    end

    // Non-overlap mode restarts the fill so the next hit needs fresh bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (clr) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= hit;
            if (in_valid) begin
                hist <= hist_nx;
                if (hit && (OVERLAP == MODE_NO_OVERLAP)) begin
                    fill <= '0;
                end else begin
                    fill <= fill_nx;
                end
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (hit),
        .count(match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed checks of seq_detector_param against a queue model.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       inp = 1'b0;
    logic [3:0] pat = 4'b1011;
    logic [3:0] msk = 4'b0000;

    logic       ma, mb, mc;
    logic [7:0] ca, cb;
    logic [1:0] cc;
    logic [2:0] fa, fb, fc;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PATTERN_W(4), .OVERLAP(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .inp(inp),
        .cfg_pattern(pat),
`ifdef SEQDET_MASK_EN
        .cfg_mask(msk),
`endif
        .match(ma), .match_cnt(ca), .fill(fa)
    );

    seq_detector_param #(.PATTERN_W(4), .OVERLAP(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .inp(inp),
        .cfg_pattern(pat),
`ifdef SEQDET_MASK_EN
        .cfg_mask(msk),
`endif
        .match(mb), .match_cnt(cb), .fill(fb)
    );

    seq_detector_param #(.PATTERN_W(4), .OVERLAP(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .inp(inp),
        .cfg_pattern(pat),
`ifdef SEQDET_MASK_EN
        .cfg_mask(msk),
`endif
        .match(mc), .match_cnt(cc), .fill(fc)
    );

    // Model: each instance keeps the bits received since the last restart.
    bit qa[$];
    bit qb[$];
    bit qc[$];
    int xa, xb, xc;
    bit ea, eb, ec;

    function automatic bit tail_eq(input bit qq[$], input logic [3:0] p,
                                   input logic [3:0] m);
        int n;
        n = qq.size();
        if (n < 4) return 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!m[3-k] && (qq[n-4+k] != p[3-k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic upd(inout bit qq[$], inout int cnt, output bit m,
                       input int ovl, input int cmax);
        logic [3:0] em;
`ifdef SEQDET_MASK_EN
        em = msk;
`else
        em = 4'b0000;
`endif
        qq.push_back(inp);
        if (qq.size() > 4) void'(qq.pop_front());
        m = tail_eq(qq, pat, em);
        if (m) begin
            if (cnt < cmax) cnt++;
            if (ovl == 0) qq.delete();
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst || clr) begin
            qa.delete(); qb.delete(); qc.delete();
            xa = 0; xb = 0; xc = 0;
            ea = 0; eb = 0; ec = 0;
        end else if (in_valid) begin
            upd(qa, xa, ea, 1, 255);
            upd(qb, xb, eb, 0, 255);
            upd(qc, xc, ec, 1, 3);
        end else begin
            ea = 0; eb = 0; ec = 0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("a.match", int'(ma), int'(ea));
            chk("a.cnt", int'(ca), xa);
            chk("a.fill", int'(fa), qa.size());
            chk("b.match", int'(mb), int'(eb));
            chk("b.cnt", int'(cb), xb);
            chk("b.fill", int'(fb), qb.size());
            chk("c.match", int'(mc), int'(ec));
            chk("c.cnt", int'(cc), xc);
            chk("c.fill", int'(fc), qc.size());
        end
    end

    // Present inputs, then let one rising edge consume them.
    task automatic step(input logic v, input logic b, input logic c);
        in_valid = v;
        inp      = b;
        clr      = c;
        @(posedge clk);
        #2;
        clr      = 1'b0;
    endtask

    initial begin
        logic [6:0] s1;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst.match", int'(ma), 0);
        chk("rst.cnt", int'(ca), 0);
        chk("rst.fill", int'(fa), 0);
        @(posedge clk);
        #2 rst = 1'b1;

        // 1,0,1,1,0,1,1 against 1011
        s1 = 7'b1011011;
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, s1[i], 1'b0);
            if (i == 3) begin
                chk("seq.a4", int'(ma), 1);
                chk("seq.b4", int'(mb), 1);
            end
        end
        chk("seq.a7", int'(ma), 1);
        chk("seq.b7", int'(mb), 0);
        chk("seq.acnt", int'(ca), 2);
        chk("seq.bcnt", int'(cb), 1);
        chk("seq.bfill", int'(fb), 3);

        // partial history equal to pattern before armed
        pat = 4'b0001;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("partial.match", int'(ma), 0);
        chk("partial.fill", int'(fa), 1);

        // gaps between valid bits
        pat = 4'b1011;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("gap.early", int'(ma), 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("gap.match", int'(ma), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("gap.idle", int'(ma), 0);
        chk("gap.cnt", int'(ca), 1);

        // clear wins over a valid bit
        step(1'b1, 1'b1, 1'b1);
        chk("clr.cnt", int'(ca), 0);
        chk("clr.fill", int'(fa), 0);

        // saturation on a run of ones
        pat = 4'b1111;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        chk("sat.c", int'(cc), 3);
        chk("sat.a", int'(ca), 7);

        // async reset after three of four bits
        pat = 4'b1011;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("arst.fill", int'(fa), 0);
        chk("arst.match", int'(ma), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk("arst.after", int'(ma), 0);
        chk("arst.fill1", int'(fa), 1);

`ifdef SEQDET_MASK_EN
        pat = 4'b1000;
        msk = 4'b0111;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("mask.hit", int'(ma), 1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
`endif

        // random stream
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                pat = 4'($urandom_range(0, 15));
`ifdef SEQDET_MASK_EN
                msk = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0000;
`endif
            end
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) == 0));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
